pi_audio_rx: RTL and testbench
==============================

PI_AUDIO_RX -- requirements
Module: pi_audio_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 256, stereo frames buffered (power of two).
REQ-002 SHALL have parameter CLK_DIV, default 1134, clk cycles per output sample period (50 MHz / 44.1 kHz).
REQ-003 SHALL have parameter TIMEOUT, default 4096, idle clk cycles after which a partial frame is discarded.
REQ-004 clk  in  1  system clock; one clock domain, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable_i  in  1  block enable; 0 = flush and idle.
REQ-007 gpio_audio_i  in  6  Pi audio chunk (GPIO[16:11]), asynchronous.
REQ-008 gpio_acl_i  in  1  Pi chunk strobe (GPIO[18]), asynchronous.
REQ-009 gpio_arq_o  out  1  audio request to Pi (GPIO[17]).
REQ-010 sample_o  out  40  {left[19:0], right[19:0]} to spdif_core sample_i.
REQ-011 sample_stb_o  out  1  one-cycle pulse when sample_o updates.
REQ-012 fifo_level_o  out  9  frames in FIFO, 0..FIFO_DEPTH.
REQ-013 underrun_cnt_o / overflow_cnt_o  out  8 each  saturating event counters.

Function
REQ-014 gpio_audio_i and gpio_acl_i SHALL each pass through a 2-FF synchronizer; ACL rising edge = synced history 2'b01; chunk captured from synced data in the same cycle the edge is detected.
REQ-015 Frame = 6 chunks: L[17:12], L[11:6], L[5:0], R[17:12], R[11:6], R[5:0]; chunk counter 0..5, wraps to 0 on frame completion.
REQ-016 On 6th chunk SHALL write {L,R} (36 bits) to FIFO in the same cycle, unless FIFO full: frame dropped, overflow_cnt_o +1 (saturate at 255).
REQ-017 gpio_arq_o SHALL be 1 iff enable_i=1 and free entries >=2; Pi starts a frame only while ARQ=1, so an in-flight frame always fits.
REQ-018 Timeout counter SHALL reset on every ACL edge; when chunk counter !=0 and counter reaches TIMEOUT, chunk counter returns to 0, partial frame discarded, no counter change.
REQ-019 Sample divider counts 0..CLK_DIV-1 and wraps; tick at wrap.
REQ-020 On tick with FIFO non-empty: pop one frame; next cycle sample_o = {L,2'b00,R,2'b00}, sample_stb_o=1.
REQ-021 On tick with FIFO empty: next cycle sample_o = 0, sample_stb_o=1, underrun_cnt_o +1 (saturate).
REQ-022 Simultaneous push and pop in one cycle SHALL both occur; fifo_level_o unchanged; full-condition push with same-cycle pop SHALL succeed.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level = wr-rd with one extra pointer bit.
REQ-024 enable_i=0: FIFO flushed, chunk counter 0, ARQ=0, ACL edges ignored, divider keeps running, ticks output zero samples without counting underrun.
REQ-025 Sign extension not required: 18-bit left-justified into 20-bit field by appending two zero LSBs.

Reset
REQ-026 rst=1 SHALL set: gpio_arq_o=0, sample_o=0, sample_stb_o=0, fifo_level_o=0, both counters 0, chunk counter 0, divider 0, timeout 0, synchronizers 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; FIFO contents undefined but pointers equal (empty).
REQ-028 First tick after reset occurs CLK_DIV cycles after rst deasserts.

Structure
REQ-029 Package pi_audio_pkg SHALL hold CHUNK_W=6, SAMPLE_W=18, OUT_W=20, CHUNKS_PER_FRAME=6, FRAME_W=36.
REQ-030 One sub-module audio_frame_fifo (synchronous, FRAME_W wide, FIFO_DEPTH deep, registered read, level output) SHALL hold buffered frames; assembler, divider, counters stay in pi_audio_rx.

Verification
REQ-031 Send 6 chunks 0x3F,0x00,0x01,0x20,0x00,0x02 -> after next tick sample_o = {20'hFC004,20'h80008}, stb 1 cycle.
REQ-032 No frames, run 3 ticks -> sample_o=0 each tick, underrun_cnt_o=3; 300 empty ticks -> saturates at 255.
REQ-033 Fill 254 frames with no ticks -> ARQ drops at level 255 (free 1); force 2 more frames -> level 256, 2nd dropped, overflow_cnt_o=1.
REQ-034 Send 3 chunks then idle 4096 cycles, then full frame F -> FIFO holds only F, level 1.
REQ-035 Frame completes on the exact tick cycle with level 256 -> pop and push both succeed, level stays 256, overflow_cnt_o=0.
REQ-036 Assert rst after 4 chunks of a frame, release, send full frame G -> next tick outputs G; all outputs 0 during reset.

Source files
------------

// File: rtl/pi_audio_pkg.sv
// Shared widths and the frame-to-sample packing for the Pi audio receiver.
package pi_audio_pkg;
  localparam int CHUNK_W          = 6;
  localparam int SAMPLE_W         = 18;
  localparam int OUT_W            = 20;
  localparam int CHUNKS_PER_FRAME = 6;
  localparam int FRAME_W          = 36;
  localparam int PAD_W            = OUT_W - SAMPLE_W;

  // 18-bit samples are left-justified into 20-bit fields
  function automatic logic [2*OUT_W-1:0] to_sample(
    input logic [FRAME_W-1:0] f
  );
    return {f[FRAME_W-1 -: SAMPLE_W], PAD_W'(0),
            f[SAMPLE_W-1:0], PAD_W'(0)};
  endfunction
endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with registered read and extra-bit pointers.
module audio_frame_fifo
  import pi_audio_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [FRAME_W-1:0] wdata,
  input  logic               pop,
  output logic [FRAME_W-1:0] rdata,
  output logic [AW:0]        level
);
  logic [FRAME_W-1:0] mem [DEPTH];
  logic [AW:0] wr;
  logic [AW:0] rd;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + (AW+1)'(1);
      if (pop)  rd <= rd + (AW+1)'(1);
    end
  end

  // a pop on a full FIFO reads the old entry before the push lands
  always_ff @(posedge clk) begin
    if (push) mem[wr[AW-1:0]] <= wdata;
    if (pop)  rdata <= mem[rd[AW-1:0]];
  end

  assign level = wr - rd;
endmodule

// File: rtl/pi_audio_rx.sv
// Pi GPIO audio receiver: rebuilds 6-bit chunks into stereo frames,
// buffers them and releases one frame per sample period.
module pi_audio_rx
  import pi_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int CLK_DIV    = 1134,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [CHUNK_W-1:0] gpio_audio_i,
  input  logic               gpio_acl_i,
  output logic               gpio_arq_o,
  output logic [2*OUT_W-1:0] sample_o,
  output logic               sample_stb_o,
  output logic [8:0]         fifo_level_o,
  output logic [7:0]         underrun_cnt_o,
  output logic [7:0]         overflow_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = FRAME_W - CHUNK_W;
  localparam logic [2:0] LAST = 3'(CHUNKS_PER_FRAME - 1);

  logic [CHUNK_W-1:0] aud_s1;
  logic [CHUNK_W-1:0] aud_s2;
  logic [2:0]         acl_s;
  logic [2:0]         chunk_cnt;
  logic [PW-1:0]      partial;
  logic [TW-1:0]      idle;
  logic [DW-1:0]      div;
  logic               have;
  logic [LW-1:0]      level;
  logic [FRAME_W-1:0] rdata;
  logic rise, last, tick, full, empty;
  logic pop, push, drop;

  always_comb begin
    rise  = enable_i && acl_s[1] && !acl_s[2];
    last  = rise && (chunk_cnt == LAST);
    tick  = (div == DW'(CLK_DIV - 1));
    full  = (level == LW'(FIFO_DEPTH));
    empty = (level == '0);
    pop   = tick && enable_i && !empty;
    push  = last && (!full || pop);
    drop  = last && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aud_s1 <= '0;
      aud_s2 <= '0;
      acl_s  <= '0;
      div    <= '0;
    end else begin
      aud_s1 <= gpio_audio_i;
      aud_s2 <= aud_s1;
      acl_s  <= {acl_s[1:0], gpio_acl_i};
      div    <= tick ? '0 : div + DW'(1);
    end
  end

  // chunk assembly; a stalled partial frame is abandoned on timeout
  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      chunk_cnt <= '0;
      partial   <= '0;
      idle      <= '0;
    end else if (rise) begin
      idle      <= '0;
      partial   <= {partial[PW-CHUNK_W-1:0], aud_s2};
      chunk_cnt <= last ? '0 : chunk_cnt + 3'd1;
    end else begin
      if (idle != TW'(TIMEOUT)) idle <= idle + TW'(1);
      else if (chunk_cnt != '0) chunk_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have           <= 1'b0;
      sample_stb_o   <= 1'b0;
      gpio_arq_o     <= 1'b0;
      underrun_cnt_o <= '0;
      overflow_cnt_o <= '0;
    end else begin
      have         <= pop;
      sample_stb_o <= tick;
      gpio_arq_o   <= enable_i &&
                      (level <= LW'(FIFO_DEPTH - 2));
      if (tick && enable_i && empty && underrun_cnt_o != 8'hFF)
        underrun_cnt_o <= underrun_cnt_o + 8'd1;
      if (drop && overflow_cnt_o != 8'hFF)
        overflow_cnt_o <= overflow_cnt_o + 8'd1;
    end
  end

  audio_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!enable_i),
    .push  (push),
    .wdata ({partial, aud_s2}),
    .pop   (pop),
    .rdata (rdata),
    .level (level)
  );

  assign sample_o     = have ? to_sample(rdata) : '0;
  assign fifo_level_o = 9'(level);
endmodule

// File: tb/tb_pi_audio_rx.sv
// Directed bench: fast-divider instance a for sample output,
// slow-divider instance b for FIFO level and overflow corners.
module tb_pi_audio_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [5:0] aud = '0;
  logic       acl = 1'b0;

  logic        arq_a, stb_a, arq_b, stb_b;
  logic [39:0] smp_a, smp_b;
  logic [8:0]  lvl_a, lvl_b;
  logic [7:0]  und_a, ovf_a, und_b, ovf_b;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  typedef struct {
    logic [35:0] frame;
    logic [39:0] exp;
  } vec_t;
  vec_t tv[4];

  pi_audio_rx #(.CLK_DIV(50)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .gpio_audio_i   (aud),
    .gpio_acl_i     (acl),
    .gpio_arq_o     (arq_a),
    .sample_o       (smp_a),
    .sample_stb_o   (stb_a),
    .fifo_level_o   (lvl_a),
    .underrun_cnt_o (und_a),
    .overflow_cnt_o (ovf_a)
  );

  pi_audio_rx #(.CLK_DIV(8000)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .gpio_audio_i   (aud),
    .gpio_acl_i     (acl),
    .gpio_arq_o     (arq_b),
    .sample_o       (smp_b),
    .sample_stb_o   (stb_b),
    .fifo_level_o   (lvl_b),
    .underrun_cnt_o (und_b),
    .overflow_cnt_o (ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // entered and left on a falling edge
  task automatic send_chunk(input logic [5:0] c);
    aud = c;
    acl = 1'b1;
    repeat (2) @(negedge clk);
    acl = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [35:0] f);
    for (int k = 0; k < 6; k++) send_chunk(f[35-6*k -: 6]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_stb(input bit sel, input int budget,
                          output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? stb_b : stb_a) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [35:0] fill(input int i);
    return {18'(i + 1), ~18'(i)};
  endfunction

  bit seen;
  int missed;

  initial begin
    tv[0] = '{frame: {6'h3F, 6'h00, 6'h01, 6'h20, 6'h00, 6'h02},
              exp: {20'hFC004, 20'h80008}};
    tv[1] = '{frame: {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F},
              exp: {20'hFFFFC, 20'hFFFFC}};
    tv[2] = '{frame: {6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06},
              exp: {20'h0420C, 20'h10518}};
    tv[3] = '{frame: {6'h2A, 6'h15, 6'h2A, 6'h15, 6'h2A, 6'h15},
              exp: {20'hA95A8, 20'h56A54}};

    @(negedge clk);
    check("reset_a", 64'({arq_a, stb_a, smp_a, lvl_a, und_a, ovf_a}), 64'd0);
    check("reset_b", 64'({arq_b, stb_b, smp_b, lvl_b, und_b, ovf_b}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(tv[i].frame);
      wait_stb(1'b0, 200, seen);
      check($sformatf("tv%0d_stb", i), 64'(seen), 64'd1);
      check($sformatf("tv%0d_sample", i), 64'(smp_a), 64'(tv[i].exp));
      @(negedge clk);
      check($sformatf("tv%0d_stb_width", i), 64'(stb_a), 64'd0);
    end

    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_stb(1'b0, 200, seen);
      check("under_stb", 64'(seen), 64'd1);
      if (k == 0) check("first_tick_cyc", 64'(cyc), 64'd50);
      check("under_sample", 64'(smp_a), 64'd0);
      @(negedge clk);
    end
    check("under_cnt3", 64'(und_a), 64'd3);

    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_stb(1'b0, 200, seen);
      check("dis_stb", 64'(seen), 64'd1);
      check("dis_sample", 64'(smp_a), 64'd0);
      @(negedge clk);
    end
    check("dis_under", 64'(und_a), 64'd3);
    check("dis_arq", 64'(arq_a), 64'd0);
    enable = 1'b1;

    missed = 0;
    for (int k = 0; k < 300; k++) begin
      wait_stb(1'b0, 200, seen);
      if (!seen) missed++;
      @(negedge clk);
    end
    check("sat_missed", 64'(missed), 64'd0);
    check("under_sat", 64'(und_a), 64'd255);

    do_reset();
    send_chunk(6'h11);
    send_chunk(6'h22);
    send_chunk(6'h33);
    repeat (4200) @(negedge clk);
    send_frame({6'h05, 6'h0A, 6'h14, 6'h28, 6'h11, 6'h22});
    check("tmo_level", 64'(lvl_b), 64'd1);
    wait_stb(1'b0, 200, seen);
    check("tmo_stb", 64'(seen), 64'd1);
    check("tmo_sample", 64'(smp_a), 64'({20'h14A50, 20'hA1188}));
    @(negedge clk);

    for (int k = 0; k < 4; k++) send_chunk(6'h3F);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_a", 64'({arq_a, stb_a, smp_a, lvl_a, und_a, ovf_a}), 64'd0);
    check("mid_rst_b", 64'({arq_b, stb_b, smp_b, lvl_b, und_b, ovf_b}), 64'd0);
    rst = 1'b0;
    send_frame({6'h30, 6'h0F, 6'h00, 6'h0C, 6'h03, 6'h3C});
    check("rst_g_level", 64'(lvl_b), 64'd1);
    wait_stb(1'b0, 200, seen);
    check("rst_g_stb", 64'(seen), 64'd1);
    check("rst_g_sample", 64'(smp_a), 64'({20'hC0F00, 20'h303F0}));
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 254; i++) send_frame(fill(i));
    check("ovf_lvl254", 64'(lvl_b), 64'd254);
    check("ovf_arq254", 64'(arq_b), 64'd1);
    send_frame(fill(254));
    check("ovf_lvl255", 64'(lvl_b), 64'd255);
    check("ovf_arq255", 64'(arq_b), 64'd0);
    send_frame(fill(255));
    check("ovf_lvl256", 64'(lvl_b), 64'd256);
    check("ovf_cnt0", 64'(ovf_b), 64'd0);
    send_frame(fill(256));
    check("ovf_lvl_drop", 64'(lvl_b), 64'd256);
    check("ovf_cnt1", 64'(ovf_b), 64'd1);

    do_reset();
    for (int i = 0; i < 256; i++) send_frame(fill(i));
    check("exact_full", 64'(lvl_b), 64'd256);
    for (int k = 0; k < 5; k++) send_chunk(6'h15);
    for (int g = 0; g < 9000 && cyc < 7997; g++) @(negedge clk);
    check("exact_align", 64'(cyc), 64'd7997);
    aud = 6'h2A;
    acl = 1'b1;
    repeat (2) @(negedge clk);
    acl = 1'b0;
    @(negedge clk);
    check("exact_stb", 64'(stb_b), 64'd1);
    check("exact_sample", 64'(smp_b), 64'({20'h00004, 20'hFFFFC}));
    check("exact_level", 64'(lvl_b), 64'd256);
    check("exact_ovf", 64'(ovf_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
